weight_burst_ctrl: RTL and testbench

- Initiator side of the weight-bank read/write interface: drives Address/WE/D toward the N-wide weight bank and captures its Q vector.
- Converts a host command into N-wide bank bursts. Reads stream out one weight per cycle; writes are gathered one weight per cycle and committed as N-wide bursts.
- Sits between the network datapath (convolution/FC engine, training update logic) and the weight bank.

---
 rtl/weight_burst_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_weight_burst_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_burst_ctrl.sv
// Host-command to N-wide weight-bank burst controller: reads stream out per lane, writes gather then commit.
// Optional WEIGHT_CKSUM_EN adds a 16-bit running sum of transferred weights on Checksum_o.
module weight_burst_ctrl #(
   parameter int N     = 10,
   parameter int DEPTH = 65,
   parameter int W     = 10,
   parameter int HOLD  = 4
) (
   input  logic                Clock_i,
   input  logic                Rst_i,
   input  logic                Start_i,
   input  logic                Mode_i,
   input  logic [6:0]          BaseAddr_i,
   input  logic [6:0]          Count_i,
   output logic                Busy_o,
   output logic                Done_o,
   output logic                Err_o,
   output logic                MemIn_o,
   output logic [6:0]          MemAddress_o,
   output logic                MemWE_o,
   output logic [N-1:0][W-1:0] MemD_o,
   input  logic [N-1:0][W-1:0] MemQ_i,
   output logic [W-1:0]        OutData_o,
   output logic                OutValid_o,
   input  logic                OutReady_i,
   input  logic [W-1:0]        InData_i,
   input  logic                InValid_i,
`ifdef WEIGHT_CKSUM_EN
   output logic [15:0]         Checksum_o,
`endif
   output logic                InReady_o
);

   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam int HW = $clog2(HOLD + 1);

   typedef enum logic [2:0] {IDLE, RD_ACC, RD_DRAIN, WR_PRE, WR_FILL, WR_ACC, FIN} state_t;

   state_t              state_q, state_d;
   logic [6:0]          ptr_q, ptr_d, rem_q, rem_d;
   logic [KW-1:0]       k_q, k_d;
   logic [HW-1:0]       hold_q, hold_d;
   logic [N-1:0][W-1:0] buf_q, buf_d;
   logic                err_q, err_d;

   logic [6:0] lanes, rem_nx;
   logic [7:0] end_addr;
   logic       hold_end, lane_end, rd_beat, wr_beat, cmd_ok;

   assign lanes    = (rem_q < 7'(N)) ? rem_q : 7'(N);
   assign rem_nx   = rem_q - lanes;
   assign end_addr = {1'b0, BaseAddr_i} + {1'b0, Count_i};
   assign hold_end = (hold_q == HW'(HOLD - 1));
   assign lane_end = (7'(k_q) == lanes - 7'd1);
   assign rd_beat  = (state_q == RD_DRAIN) && OutReady_i;
   assign wr_beat  = (state_q == WR_FILL) && InValid_i;
   assign cmd_ok   = (Count_i != 7'd0) && (end_addr <= 8'(DEPTH));

   assign Err_o   = err_q;
   assign MemIn_o = 1'b0;

   always_ff @(posedge Clock_i) begin
      if (Rst_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         k_q     <= '0;
         hold_q  <= '0;
         buf_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         k_q     <= k_d;
         hold_q  <= hold_d;
         buf_q   <= buf_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      rem_d        = rem_q;
      k_d          = k_q;
      hold_d       = hold_q;
      buf_d        = buf_q;
      err_d        = 1'b0;
      Busy_o       = (state_q != IDLE);
      Done_o       = (state_q == FIN);
      MemAddress_o = '0;
      MemWE_o      = 1'b0;
      MemD_o       = '0;
      OutData_o    = '0;
      OutValid_o   = 1'b0;
      InReady_o    = 1'b0;
      case (state_q)
         IDLE: begin
            if (Start_i) begin
               if (!cmd_ok) begin
                  err_d = 1'b1;
               end else begin
                  ptr_d  = BaseAddr_i;
                  rem_d  = Count_i;
                  k_d    = '0;
                  hold_d = '0;
                  // Partial first write burst needs a read first so untouched lanes survive.
                  if (!Mode_i)                state_d = RD_ACC;
                  else if (Count_i < 7'(N))   state_d = WR_PRE;
                  else                        state_d = WR_FILL;
               end
            end
         end
         RD_ACC, WR_PRE: begin
            MemAddress_o = ptr_q;
            hold_d       = hold_q + HW'(1);
            if (hold_end) begin
               hold_d  = '0;
               buf_d   = MemQ_i;
               k_d     = '0;
               state_d = (state_q == RD_ACC) ? RD_DRAIN : WR_FILL;
            end
         end
         RD_DRAIN: begin
            OutValid_o = 1'b1;
            OutData_o  = buf_q[k_q];
            if (rd_beat) begin
               if (lane_end) begin
                  k_d     = '0;
                  ptr_d   = ptr_q + lanes;
                  rem_d   = rem_nx;
                  state_d = (rem_nx != 7'd0) ? RD_ACC : FIN;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
         end
         WR_FILL: begin
            InReady_o = 1'b1;
            if (wr_beat) begin
               buf_d[k_q] = InData_i;
               if (lane_end) begin
                  k_d     = '0;
                  hold_d  = '0;
                  state_d = WR_ACC;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
         end
         WR_ACC: begin
            MemAddress_o = ptr_q;
            MemWE_o      = 1'b1;
            MemD_o       = buf_q;
            hold_d       = hold_q + HW'(1);
            if (hold_end) begin
               hold_d = '0;
               ptr_d  = ptr_q + lanes;
               rem_d  = rem_nx;
               if (rem_nx == 7'd0)      state_d = FIN;
               else if (rem_nx < 7'(N)) state_d = WR_PRE;
               else                     state_d = WR_FILL;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef WEIGHT_CKSUM_EN
   logic [15:0] cks_q;

   always_ff @(posedge Clock_i) begin
      if (Rst_i)                                    cks_q <= '0;
      else if (state_q == IDLE && Start_i && cmd_ok) cks_q <= '0;
      else if (rd_beat)                             cks_q <= cks_q + 16'(buf_q[k_q]);
      else if (wr_beat)                             cks_q <= cks_q + 16'(InData_i);
   end

   assign Checksum_o = cks_q;
`endif

endmodule

// File: tb/tb_weight_burst_ctrl.sv
// Directed bench for weight_burst_ctrl with a behavioural weight bank (preloaded w[i]=i+1).
module tb_weight_burst_ctrl;
   localparam int N = 10, DEPTH = 65, W = 10, HOLD = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst, start, mode, out_ready, in_valid;
   logic [6:0]          base, count;
   logic [W-1:0]        in_data;
   logic                busy, done, err, mem_in, mem_we, out_valid, in_ready;
   logic [6:0]          mem_addr;
   logic [N-1:0][W-1:0] mem_d, mem_q;
   logic [W-1:0]        out_data;
`ifdef WEIGHT_CKSUM_EN
   logic [15:0]         cksum;
`endif

   weight_burst_ctrl #(.N(N), .DEPTH(DEPTH), .W(W), .HOLD(HOLD)) dut (
      .Clock_i(clk), .Rst_i(rst), .Start_i(start), .Mode_i(mode),
      .BaseAddr_i(base), .Count_i(count), .Busy_o(busy), .Done_o(done),
      .Err_o(err), .MemIn_o(mem_in), .MemAddress_o(mem_addr), .MemWE_o(mem_we),
      .MemD_o(mem_d), .MemQ_i(mem_q), .OutData_o(out_data), .OutValid_o(out_valid),
      .OutReady_i(out_ready), .InData_i(in_data), .InValid_i(in_valid),
`ifdef WEIGHT_CKSUM_EN
      .Checksum_o(cksum),
`endif
      .InReady_o(in_ready)
   );

   logic [W-1:0] mem [DEPTH];
   logic         bank_init;

   always @(posedge clk) begin
      if (bank_init) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= W'(i + 1);
      end else if (mem_we) begin
         for (int k = 0; k < N; k++)
            if (int'(mem_addr) + k < DEPTH) mem[int'(mem_addr) + k] <= mem_d[k];
      end
   end

   always_comb begin
      mem_q = '0;
      for (int k = 0; k < N; k++)
         if (int'(mem_addr) + k < DEPTH) mem_q[k] = mem[int'(mem_addr) + k];
   end

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int max, input string tag);
      bit found = 0;
      for (int i = 0; i < max; i++) begin
         #1;
         if (done) begin
            found = 1;
            break;
         end
         step();
      end
      chk(tag, 32'(found), 1);
   endtask

   initial begin
      int beats, n_wr;
      bit toggle, seen, rd30;
      logic [6:0] wr_addr [2];
      logic we_prev;

      rst = 1; start = 0; mode = 0; base = 0; count = 0;
      out_ready = 0; in_valid = 0; in_data = 0; bank_init = 1;
      step(); step();
      bank_init = 0;
      #1;
      chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
      chk("rst_err", err, 0);        chk("rst_memin", mem_in, 0);
      chk("rst_addr", mem_addr, 0);  chk("rst_we", mem_we, 0);
      chk("rst_memd", 32'(mem_d[0]) | 32'(mem_d[N-1]), 0);
      chk("rst_ovalid", out_valid, 0); chk("rst_inready", in_ready, 0);
      rst = 0;
      step();

      // Read 10 weights from 0 with a free-running sink.
      start = 1; mode = 0; base = 0; count = 10; out_ready = 1;
      step();
      start = 0;
      for (int h = 0; h < HOLD; h++) begin
         #1;
         chk("t1_addr", mem_addr, 0); chk("t1_we", mem_we, 0);
         chk("t1_busy", busy, 1);     chk("t1_ovalid_hold", out_valid, 0);
         step();
      end
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("t1_ovalid", out_valid, 1);
         chk("t1_data", out_data, 32'(i + 1));
         chk("t1_nodone", done, 0);
         step();
      end
      #1;
      chk("t1_done", done, 1);
`ifdef WEIGHT_CKSUM_EN
      chk("t1_cksum", cksum, 55);
`endif
      step();
      #1;
      chk("t1_done_pulse", done, 0);
      chk("t1_idle", busy, 0);

      // Read 5 at the top of the bank with a 1,0,1,0 ready pattern.
      start = 1; base = 60; count = 5;
      step();
      start = 0;
      beats = 0; toggle = 1; seen = 0;
      for (int c = 0; c < 60; c++) begin
         out_ready = toggle;
         #1;
         if (done) begin
            seen = 1;
            break;
         end
         if (out_valid) begin
            chk("t2_data", out_data, 32'(61 + beats));
            if (out_ready) beats++;
            toggle = ~toggle;
         end
         step();
      end
      chk("t2_done", 32'(seen), 1);
      chk("t2_beats", beats, 5);
      step();
      out_ready = 1;
      start = 1; base = 60; count = 6;
      step();
      start = 0;
      #1;
      chk("t2_err", err, 1);
      chk("t2_err_busy", busy, 0);
      step();
      #1;
      chk("t2_err_pulse", err, 0);
      chk("t2_err_idle", busy, 0);

      // Write 13 weights at 20: full burst then a read-modify-write partial burst.
      start = 1; mode = 1; base = 20; count = 13;
      step();
      start = 0; in_valid = 1;
      beats = 0; n_wr = 0; rd30 = 0; seen = 0; we_prev = 0;
      wr_addr[0] = '0; wr_addr[1] = '0;
      for (int c = 0; c < 200; c++) begin
         in_data = W'(100 + beats);
         #1;
         if (done) begin
            seen = 1;
            break;
         end
         if (mem_we && !we_prev) begin
            if (n_wr < 2) wr_addr[n_wr] = mem_addr;
            if (n_wr == 1) begin
               chk("t3_lane0", mem_d[0], 110);
               chk("t3_lane2", mem_d[2], 112);
               chk("t3_lane3_rmw", mem_d[3], 34);
            end
            n_wr++;
         end
         if (busy && !mem_we && mem_addr == 7'd30 && n_wr == 1) rd30 = 1;
         if (in_ready) beats++;
         we_prev = mem_we;
         step();
      end
      in_valid = 0;
      chk("t3_done", 32'(seen), 1);
      chk("t3_beats", beats, 13);
      chk("t3_nwr", n_wr, 2);
      chk("t3_wr0_addr", wr_addr[0], 20);
      chk("t3_wr1_addr", wr_addr[1], 30);
      chk("t3_rmw_read", 32'(rd30), 1);
      for (int i = 0; i < 13; i++) chk("t3_mem_new", mem[20 + i], 32'(100 + i));
      for (int i = 33; i < 40; i++) chk("t3_mem_kept", mem[i], 32'(i + 1));
      chk("t3_mem_below", mem[19], 20);
      step();

      // Reset in the middle of the fourth gather beat.
      start = 1; mode = 1; base = 40; count = 10;
      step();
      start = 0; in_valid = 1; beats = 0;
      for (int c = 0; c < 50; c++) begin
         in_data = W'(200 + beats);
         #1;
         if (in_ready) begin
            if (beats == 3) break;
            beats++;
         end
         step();
      end
      chk("t4_beats_before", beats, 3);
      rst = 1;
      step();
      #1;
      chk("t4_busy", busy, 0);     chk("t4_done", done, 0);
      chk("t4_err", err, 0);       chk("t4_we", mem_we, 0);
      chk("t4_addr", mem_addr, 0); chk("t4_inready", in_ready, 0);
      chk("t4_memd", 32'(mem_d[0]) | 32'(mem_d[3]), 0);
      rst = 0; in_valid = 0;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         #1;
         if (done || mem_we || busy) seen = 1;
      end
      chk("t4_quiet", 32'(seen), 0);
      for (int i = 40; i < 50; i++) chk("t4_mem_kept", mem[i], 32'(i + 1));

      // Start while busy is ignored; Count=0 in idle is rejected.
      start = 1; mode = 0; base = 0; count = 2; out_ready = 1;
      step();
      count = 0;
      step();
      start = 0;
      #1;
      chk("t5_busy_noerr", err, 0);
      chk("t5_busy", busy, 1);
      wait_done(40, "t5_done");
      step();
      start = 1; count = 0;
      step();
      start = 0;
      #1;
      chk("t5_err", err, 1);
      chk("t5_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
